// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Multi-PLL lock supervisor and reset sequencer running on the board
// reference clock. Every PLL channel has its own reset/lock state machine.
// Each machine holds its PLL in reset, waits a bounded time for lock and
// debounces the lock. It retries after a timeout or a lock loss and parks
// in FAIL once the retries are used up. The design-wide reset is released
// only after every channel has reached LOCKED.
//
// Ports
//   clkin_i       reference clock, the only clock of the block
//   rst_n_i       asynchronous active-low reset
//   pll_lock_i    raw lock from each PLL, asynchronous to clkin_i
//   retry_req_i   single-cycle pulse, restarts every channel sitting in FAIL
//   pll_rst_o     active-high reset to each PLL
//   locked_o      per-channel accepted-lock status
//   pll_fail_o    per-channel permanent-failure flag
//   lock_lost_o   one-cycle pulse when a LOCKED channel drops lock
//   all_locked_o  registered AND of locked_o
//   sys_rst_n_o   active-low design reset, registered copy of all_locked_o
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int NUM_PLL             = 2,
    parameter int PLL_RST_CYCLES      = 24,
    parameter int LOCK_TIMEOUT_CYCLES = 240000,
    parameter int LOCK_STABLE_CYCLES  = 2400,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               clkin_i,
    input  logic               rst_n_i,
    input  logic [NUM_PLL-1:0] pll_lock_i,
    input  logic               retry_req_i,
    output logic [NUM_PLL-1:0] pll_rst_o,
    output logic [NUM_PLL-1:0] locked_o,
    output logic [NUM_PLL-1:0] pll_fail_o,
    output logic [NUM_PLL-1:0] lock_lost_o,
    output logic               all_locked_o,
    output logic               sys_rst_n_o
);

    // One shared counter per channel serves all three timed phases, so it
    // is sized for the longest of them.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ?
                             MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [RTY_W-1:0] RTY_ONE     = RTY_W'(1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous lock inputs
    // -----------------------------------------------------------------------
    logic [NUM_PLL-1:0] lock_meta_q;
    logic [NUM_PLL-1:0] lock_s_q;

    always_ff @(posedge clkin_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_meta_q <= '0;
            lock_s_q    <= '0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel state machines
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [RTY_W-1:0] rty_q, rty_d;
        logic [RTY_W-1:0] rty_inc;
        logic             rst_q, rst_d;
        logic             lck_q, lck_d;
        logic             fail_q, fail_d;
        logic             lost_q, lost_d;

        assign rty_inc = rty_q + RTY_ONE;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q + CNT_ONE;
            rty_d   = rty_q;
            lost_d  = 1'b0;

            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT: begin
                    // Lock is tested first so that a lock arriving on the
                    // timeout cycle wins and costs no retry.
                    if (lock_s_q[g]) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        rty_d   = rty_inc;
                        cnt_d   = '0;
                        state_d = (rty_inc == RTY_LIMIT) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    // A drop while debouncing restarts the timeout window
                    // but keeps the retry count of the current attempt.
                    if (!lock_s_q[g]) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    cnt_d = '0;
                    // A lock loss is not a timeout and so is not counted
                    // as a retry.
                    if (!lock_s_q[g]) begin
                        state_d = ST_RESET;
                        lost_d  = 1'b1;
                    end
                end
                ST_FAIL: begin
                    cnt_d = '0;
                    if (retry_req_i) begin
                        state_d = ST_RESET;
                        rty_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    rty_d   = '0;
                end
            endcase

            // Outputs are decoded from the next state so that they move on
            // the same edge as the transition.
            rst_d  = (state_d == ST_RESET) || (state_d == ST_FAIL);
            lck_d  = (state_d == ST_LOCKED);
            fail_d = (state_d == ST_FAIL);
        end

        always_ff @(posedge clkin_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q <= ST_RESET;
                cnt_q   <= '0;
                rty_q   <= '0;
                rst_q   <= 1'b1;
                lck_q   <= 1'b0;
                fail_q  <= 1'b0;
                lost_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rty_q   <= rty_d;
                rst_q   <= rst_d;
                lck_q   <= lck_d;
                fail_q  <= fail_d;
                lost_q  <= lost_d;
            end
        end

        assign pll_rst_o[g]   = rst_q;
        assign locked_o[g]    = lck_q;
        assign pll_fail_o[g]  = fail_q;
        assign lock_lost_o[g] = lost_q;
    end

    // -----------------------------------------------------------------------
    // Design-wide lock status and reset release
    // -----------------------------------------------------------------------
    logic all_locked_q;
    logic sys_rst_n_q;

    always_ff @(posedge clkin_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            all_locked_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
        end else begin
            all_locked_q <= &locked_o;
            sys_rst_n_q  <= all_locked_q;
        end
    end

    assign all_locked_o = all_locked_q;
    assign sys_rst_n_o  = sys_rst_n_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int NP  = 2;
    localparam int PRC = 4;
    localparam int TO  = 32;
    localparam int STC = 8;
    localparam int MR  = 2;

    // {pll_rst, locked, pll_fail, lock_lost, all_locked, sys_rst_n}
    localparam logic [4*NP+1:0] RST_VEC = 10'b11_00_00_00_0_0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NP-1:0] pll_lock = '0;
    logic          retry_req = 1'b0;
    logic [NP-1:0] pll_rst, locked, pll_fail, lock_lost;
    logic          all_locked, sys_rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .NUM_PLL(NP), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES(STC), .MAX_RETRIES(MR)
    ) dut (
        .clkin_i(clk), .rst_n_i(rst_n), .pll_lock_i(pll_lock),
        .retry_req_i(retry_req), .pll_rst_o(pll_rst), .locked_o(locked),
        .pll_fail_o(pll_fail), .lock_lost_o(lock_lost),
        .all_locked_o(all_locked), .sys_rst_n_o(sys_rst_n)
    );

    // ---------------- reference model (phase + entry timestamp) ------------
    localparam int P_RESETTING = 0;
    localparam int P_WAITING   = 1;
    localparam int P_SETTLING  = 2;
    localparam int P_LOCKED    = 3;
    localparam int P_FAILED    = 4;

    int            ph[NP];
    int            t0[NP];
    int            tries[NP];
    int            cyc;
    logic [NP-1:0] h1, h2, ls;
    logic [NP-1:0] m_rst, m_lck, m_fail, m_lost;
    logic          m_all, m_sys;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; h1 = '0; h2 = '0; ls = '0;
            m_rst = '1; m_lck = '0; m_fail = '0; m_lost = '0;
            m_all = 1'b0; m_sys = 1'b0;
            for (int c = 0; c < NP; c++) begin
                ph[c] = P_RESETTING; t0[c] = 0; tries[c] = 0;
            end
        end else begin
            ls = h2; h2 = h1; h1 = pll_lock;
            cyc++;
            m_sys = m_all;
            m_all = &m_lck;
            for (int c = 0; c < NP; c++) begin
                m_lost[c] = 1'b0;
                if (ph[c] == P_RESETTING) begin
                    if (cyc - t0[c] == PRC) begin ph[c] = P_WAITING; t0[c] = cyc; end
                end else if (ph[c] == P_WAITING) begin
                    if (ls[c]) begin
                        ph[c] = P_SETTLING; t0[c] = cyc;
                    end else if (cyc - t0[c] == TO) begin
                        tries[c]++;
                        t0[c] = cyc;
                        ph[c] = (tries[c] == MR) ? P_FAILED : P_RESETTING;
                    end
                end else if (ph[c] == P_SETTLING) begin
                    if (!ls[c]) begin
                        ph[c] = P_WAITING; t0[c] = cyc;
                    end else if (cyc - t0[c] == STC) begin
                        ph[c] = P_LOCKED; tries[c] = 0;
                    end
                end else if (ph[c] == P_LOCKED) begin
                    if (!ls[c]) begin ph[c] = P_RESETTING; t0[c] = cyc; m_lost[c] = 1'b1; end
                end else begin
                    if (retry_req) begin ph[c] = P_RESETTING; t0[c] = cyc; tries[c] = 0; end
                end
                m_rst[c]  = (ph[c] == P_RESETTING) || (ph[c] == P_FAILED);
                m_lck[c]  = (ph[c] == P_LOCKED);
                m_fail[c] = (ph[c] == P_FAILED);
            end
        end
    end

    logic [4*NP+1:0] dut_v, mdl_v;
    assign dut_v = {pll_rst, locked, pll_fail, lock_lost, all_locked, sys_rst_n};
    assign mdl_v = {m_rst, m_lck, m_fail, m_lost, m_all, m_sys};

    // Puts the DUT in reset for two cycles and releases it at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pll_lock = '0; retry_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        pll_lock = '0; retry_req = 1'b0;
        #1;
        n_cmp++;
        if (dut_v !== RST_VEC) begin
            n_bad++; $display("FAIL reset_immediate: got %b want %b", dut_v, RST_VEC);
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== RST_VEC) begin
                n_bad++; $display("FAIL reset_held: got %b want %b", dut_v, RST_VEC);
            end
        end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL nominal_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            if (i == 3 || i == 4) begin
                n_cmp++;
                if (pll_rst !== ((i == 3) ? 2'b11 : 2'b00)) begin
                    n_bad++; $display("FAIL nominal_pll_rst i=%0d: got %b", i, pll_rst);
                end
            end
            if (i == 19 || i == 20) begin
                n_cmp++;
                if (locked !== ((i == 20) ? 2'b11 : 2'b00)) begin
                    n_bad++; $display("FAIL nominal_locked i=%0d: got %b", i, locked);
                end
            end
            if (i == 20 || i == 21) begin
                n_cmp++;
                if (all_locked !== (i == 21)) begin
                    n_bad++; $display("FAIL nominal_all_locked i=%0d: got %b", i, all_locked);
                end
            end
            if (i == 21 || i == 22) begin
                n_cmp++;
                if (sys_rst_n !== (i == 22)) begin
                    n_bad++; $display("FAIL nominal_sys_rst_n i=%0d: got %b", i, sys_rst_n);
                end
            end
            if (i == 9) pll_lock = 2'b11;
        end
    endtask

    task automatic test_debounce();
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL debounce_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            if (i == 20 || i == 25 || i == 26) begin
                n_cmp++;
                if (locked !== ((i == 26) ? 2'b11 : 2'b10)) begin
                    n_bad++; $display("FAIL debounce_locked i=%0d: got %b", i, locked);
                end
            end
            if (i == 9)  pll_lock = 2'b11;
            if (i == 14) pll_lock[0] = 1'b0;
            if (i == 15) pll_lock[0] = 1'b1;
        end
    endtask

    task automatic test_timeout_fail();
        do_reset();
        pll_lock = 2'b01;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL timeout_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            if (i == 71) begin
                n_cmp++;
                if (pll_fail !== 2'b00) begin
                    n_bad++; $display("FAIL timeout_early_fail: got %b want 00", pll_fail);
                end
            end
            if (i == 72) begin
                n_cmp++;
                if ({pll_fail[1], pll_rst[1], sys_rst_n} !== 3'b110) begin
                    n_bad++; $display("FAIL timeout_fail72: got fail/rst/sys %b want 110",
                                      {pll_fail[1], pll_rst[1], sys_rst_n});
                end
            end
            if (i == 81 || i == 84 || i == 85) begin
                n_cmp++;
                if ({pll_fail[1], pll_rst[1]} !== ((i == 85) ? 2'b00 : 2'b01)) begin
                    n_bad++; $display("FAIL retry_restart i=%0d: got fail/rst %b",
                                      i, {pll_fail[1], pll_rst[1]});
                end
            end
            if (i == 93 || i == 94) begin
                n_cmp++;
                if (locked !== ((i == 94) ? 2'b11 : 2'b01)) begin
                    n_bad++; $display("FAIL retry_locked i=%0d: got %b", i, locked);
                end
            end
            if (i == 95 || i == 96) begin
                n_cmp++;
                if ({all_locked, sys_rst_n} !== ((i == 96) ? 2'b11 : 2'b10)) begin
                    n_bad++; $display("FAIL retry_sys i=%0d: got %b", i, {all_locked, sys_rst_n});
                end
            end
            if (i == 80) begin retry_req = 1'b1; pll_lock = 2'b11; end
            if (i == 81) retry_req = 1'b0;
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL lossm_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            if (i == 33) begin
                n_cmp++;
                if ({lock_lost, locked, pll_rst} !== 6'b01_10_01) begin
                    n_bad++; $display("FAIL loss_edge: got lost/locked/rst %b want 011001",
                                      {lock_lost, locked, pll_rst});
                end
            end
            if (i == 34) begin
                n_cmp++;
                if ({lock_lost, all_locked, sys_rst_n} !== 4'b00_0_1) begin
                    n_bad++; $display("FAIL loss_next: got lost/all/sys %b want 0001",
                                      {lock_lost, all_locked, sys_rst_n});
                end
            end
            if (i == 35) begin
                n_cmp++;
                if (sys_rst_n !== 1'b0) begin
                    n_bad++; $display("FAIL loss_sys: got %b want 0", sys_rst_n);
                end
            end
            if (i == 36 || i == 37) begin
                n_cmp++;
                if (pll_rst !== ((i == 36) ? 2'b01 : 2'b00)) begin
                    n_bad++; $display("FAIL loss_pll_rst i=%0d: got %b", i, pll_rst);
                end
            end
            if (i >= 20) begin
                n_cmp++;
                if (locked[1] !== 1'b1) begin
                    n_bad++; $display("FAIL loss_other_ch i=%0d: got %b want 1", i, locked[1]);
                end
            end
            if (i == 9)  pll_lock = 2'b11;
            if (i == 30) pll_lock[0] = 1'b0;
            if (i == 38) pll_lock[0] = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL simul_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            if (i == 35 || i == 36) begin
                n_cmp++;
                if (pll_rst !== ((i == 36) ? 2'b10 : 2'b00)) begin
                    n_bad++; $display("FAIL simul_timeout_edge i=%0d: got %b", i, pll_rst);
                end
            end
            if (i == 71 || i == 72) begin
                n_cmp++;
                if ({pll_rst, pll_fail} !== ((i == 72) ? 4'b11_10 : 4'b00_00)) begin
                    n_bad++; $display("FAIL simul_retry_count i=%0d: got rst/fail %b",
                                      i, {pll_rst, pll_fail});
                end
            end
            if (i == 10 || i == 50) retry_req = 1'b1;
            if (i == 11 || i == 51) retry_req = 1'b0;
            if (i == 33) pll_lock = 2'b01;
            if (i == 37) pll_lock = 2'b00;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 9) pll_lock = 2'b11;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_v !== RST_VEC) begin
            n_bad++; $display("FAIL async_reset: got %b want %b", dut_v, RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL async_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            if (i == 3 || i == 4) begin
                n_cmp++;
                if (pll_rst !== ((i == 3) ? 2'b11 : 2'b00)) begin
                    n_bad++; $display("FAIL async_restart_rst i=%0d: got %b", i, pll_rst);
                end
            end
            if (i == 12 || i == 13) begin
                n_cmp++;
                if (locked !== ((i == 13) ? 2'b11 : 2'b00)) begin
                    n_bad++; $display("FAIL async_restart_locked i=%0d: got %b", i, locked);
                end
            end
        end
    endtask

    task automatic test_random();
        int rate;
        do_reset();
        for (int i = 1; i <= 1500; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== mdl_v) begin
                n_bad++; $display("FAIL random_model i=%0d: got %b want %b", i, dut_v, mdl_v);
            end
            rate = (i < 700) ? 60 : 8;
            for (int c = 0; c < NP; c++)
                if ($urandom_range(0, rate) == 0) pll_lock[c] = ~pll_lock[c];
            retry_req = ($urandom_range(0, 24) == 0);
        end
        retry_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_debounce();
        test_timeout_fail();
        test_lock_loss();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
